updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/counter_pkg.sv | 12 +
 rtl/bin2gray.sv | 11 +
 rtl/updown_mod_counter.sv | 127 ++++++++++++
 tb/tb_updown_mod_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter: FSM state encodings.
package counter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SAT  = 2'b10
  } state_e;

endpackage

// File: rtl/bin2gray.sv
// Binary to reflected Gray code converter (purely combinational).
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap pulse and optional saturation.
// Define GRAY_OUT_EN to add the registered count_gray output.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
`ifdef GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] count_gray
`endif
);

  localparam logic [WIDTH:0] MAX_EXT  = (WIDTH + 1)'(MODULO - 1);
  localparam logic [WIDTH:0] ZERO_EXT = {(WIDTH + 1){1'b0}};
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH + 1)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic [WIDTH:0]   load_clamp_s;
  logic [WIDTH:0]   step_ext_s;
  logic             at_end_s;
  logic [WIDTH-1:0] step_count_s;
  logic             step_wrap_s;
  logic             step_sat_s;

  assign cnt_ext_s    = {1'b0, count_q};
  assign load_ext_s   = {1'b0, load_val};
  assign load_clamp_s = (load_ext_s > MAX_EXT) ? MAX_EXT : load_ext_s;
  assign at_end_s     = up_dn ? (cnt_ext_s == MAX_EXT) : (cnt_ext_s == ZERO_EXT);
  assign step_ext_s   = up_dn ? (cnt_ext_s + ONE_EXT) : (cnt_ext_s - ONE_EXT);

  // Result of one enabled step: ordinary move, wrap to the opposite end, or hold.
  always_comb begin
    step_count_s = WIDTH'(step_ext_s);
    step_wrap_s  = 1'b0;
    step_sat_s   = 1'b0;
    if (at_end_s) begin
      if (SATURATE != 0) begin
        step_count_s = count_q;
        step_sat_s   = 1'b1;
      end else begin
        step_count_s = up_dn ? WIDTH'(ZERO_EXT) : WIDTH'(MAX_EXT);
        step_wrap_s  = 1'b1;
      end
    end else begin
      step_count_s = WIDTH'(step_ext_s);
    end
  end

  // Next-state logic: reset > load > en; any illegal state recovers to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (reset) begin
      count_d = {WIDTH{1'b0}};
    end else if (load) begin
      count_d = WIDTH'(load_clamp_s);
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN, ST_SAT: begin
          if (en) begin
            count_d = step_count_s;
            wrap_d  = step_wrap_s;
            sat_d   = step_sat_s;
            state_d = step_sat_s ? ST_SAT : ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    count_q <= count_d;
    wrap_q  <= wrap_d;
    sat_q   <= sat_d;
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;
  assign tc    = en & ~load & at_end_s;

`ifdef GRAY_OUT_EN
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] gray_q;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .bin_i  (count_d),
    .gray_o (gray_d)
  );

  // Gray register tracks count_d so it matches count on the same cycle.
  always_ff @(posedge clk) begin
    gray_q <= gray_d;
  end

  assign count_gray = gray_q;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized + directed bench for updown_mod_counter against an integer model.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [2:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c, sat_a, sat_b, sat_c;
`ifdef GRAY_OUT_EN
  logic [2:0] g_a, g_b;
  logic [3:0] g_c;
`endif

  updown_mod_counter #(.WIDTH(3), .MODULO(6), .SATURATE(0)) u_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[2:0]),
    .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .sat(sat_a)
`ifdef GRAY_OUT_EN
    , .count_gray(g_a)
`endif
  );

  updown_mod_counter #(.WIDTH(3), .MODULO(6), .SATURATE(1)) u_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[2:0]),
    .count(cnt_b), .tc(tc_b), .wrap(wrap_b), .sat(sat_b)
`ifdef GRAY_OUT_EN
    , .count_gray(g_b)
`endif
  );

  updown_mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(0)) u_c (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv),
    .count(cnt_c), .tc(tc_c), .wrap(wrap_c), .sat(sat_c)
`ifdef GRAY_OUT_EN
    , .count_gray(g_c)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one entry per instance; state uses the documented encodings 0/1/2.
  int mods[3] = '{6, 6, 16};
  int sats[3] = '{0, 1, 0};
  int lmask[3] = '{7, 7, 15};
  int mc[3], mw[3], ms[3], mst[3];
  bit mvalid = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int act_cnt(input int k);
    case (k)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  function automatic int act_tc(input int k);
    case (k)
      0: return int'(tc_a);
      1: return int'(tc_b);
      default: return int'(tc_c);
    endcase
  endfunction

  function automatic int act_wrap(input int k);
    case (k)
      0: return int'(wrap_a);
      1: return int'(wrap_b);
      default: return int'(wrap_c);
    endcase
  endfunction

  function automatic int act_sat(input int k);
    case (k)
      0: return int'(sat_a);
      1: return int'(sat_b);
      default: return int'(sat_c);
    endcase
  endfunction

  function automatic int act_st(input int k);
    case (k)
      0: return int'(u_a.state_q);
      1: return int'(u_b.state_q);
      default: return int'(u_c.state_q);
    endcase
  endfunction

`ifdef GRAY_OUT_EN
  function automatic int act_gray(input int k);
    case (k)
      0: return int'(g_a);
      1: return int'(g_b);
      default: return int'(g_c);
    endcase
  endfunction
`endif

  // One clock: check tc against current inputs, advance model, check registers.
  task automatic cycle();
    int m, v, exp_tc;
    bit at_end;
    #1;
    for (int k = 0; k < 3; k++) begin
      m = mods[k];
      if (mvalid) begin
        exp_tc = (en && !load && ((up_dn && mc[k] == m - 1) || (!up_dn && mc[k] == 0))) ? 1 : 0;
        chk($sformatf("tc[%0d]", k), act_tc(k), exp_tc);
      end
      mw[k] = 0;
      ms[k] = 0;
      if (reset) begin
        mc[k] = 0; mst[k] = 0;
      end else if (load) begin
        v = int'(lv) & lmask[k];
        mc[k] = (v >= m) ? m - 1 : v;
        mst[k] = 0;
      end else if (en) begin
        at_end = up_dn ? (mc[k] == m - 1) : (mc[k] == 0);
        if (at_end && sats[k] != 0) begin
          ms[k] = 1; mst[k] = 2;
        end else if (at_end) begin
          mc[k] = up_dn ? 0 : m - 1; mw[k] = 1; mst[k] = 1;
        end else begin
          mc[k] = up_dn ? mc[k] + 1 : mc[k] - 1; mst[k] = 1;
        end
      end else begin
        mst[k] = 0;
      end
    end
    if (reset) mvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("count[%0d]", k), act_cnt(k), mc[k]);
        chk($sformatf("wrap[%0d]", k), act_wrap(k), mw[k]);
        chk($sformatf("sat[%0d]", k), act_sat(k), ms[k]);
        chk($sformatf("state[%0d]", k), act_st(k), mst[k]);
`ifdef GRAY_OUT_EN
        chk($sformatf("gray[%0d]", k), act_gray(k), mc[k] ^ (mc[k] >> 1));
`endif
      end
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] v);
    reset = r; en = e; up_dn = u; load = l; lv = v;
    cycle();
  endtask

  int exp_up[7]   = '{1, 2, 3, 4, 5, 0, 1};
  int exp_dn[3]   = '{5, 4, 3};
  int exp_gray[6] = '{0, 1, 3, 2, 6, 7};

  initial begin
    @(negedge clk);
    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("reset_count", int'(cnt_a), 0);
    chk("reset_wrap", int'(wrap_a), 0);

    // Count up through the wrap
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("up_count", int'(cnt_a), exp_up[i]);
      chk("up_wrap", int'(wrap_a), (exp_up[i] == 0) ? 1 : 0);
    end

    // Count down from 0: tc seen at 0, wrap with count 5
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0; en = 1'b1; up_dn = 1'b0; load = 1'b0;
    #1;
    chk("down_tc_at0", int'(tc_a), 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("down_count", int'(cnt_a), exp_dn[i]);
      chk("down_wrap", int'(wrap_a), (i == 0) ? 1 : 0);
    end

    // Saturation at the top, then release downward
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("sat_hold_count", int'(cnt_b), 5);
    chk("sat_flag", int'(sat_b), 1);
    chk("sat_no_wrap", int'(wrap_b), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("sat_release_count", int'(cnt_b), 4);
    chk("sat_release_flag", int'(sat_b), 0);
    chk("sat_release_state", int'(u_b.state_q), 1);

    // Load clamping and load-over-enable priority
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
    chk("load_clamp", int'(cnt_a), 5);
    chk("load_noclamp_w4", int'(cnt_c), 7);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
    chk("load_wins", int'(cnt_a), 2);

    // Reset beats load and enable mid-count
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("pre_reset_count", int'(cnt_a), 3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd4);
    chk("reset_override_count", int'(cnt_a), 0);
    chk("reset_override_state", int'(u_a.state_q), 0);

`ifdef GRAY_OUT_EN
    chk("gray_lit", int'(g_a), exp_gray[0]);
    for (int i = 1; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      chk("gray_lit", int'(g_a), exp_gray[i]);
    end
`endif

    // Randomized traffic
    up_dn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 7) == 0) ? ~up_dn : up_dn,
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
